count_run_sched: RTL
====================

# count_run_sched

Round-robin scheduler that shares one W-bit run counter among NREQ requesters. Each requester asks for a run of `len` counts in binary, Gray or one-hot encoding. The block grants one requester at a time, sequences the counter through exactly `len` values, and reports completion with a one-cycle `done` pulse. It sits between client blocks and the shared counter/encoder datapath and owns that resource completely.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 8: counter/output width; power of two, ≥4.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  request per requester; must hold high until `done` or abort.
- `len`  in  NREQ*W  run length for requester i in bits [i*W +: W]; value 0 means 2^W.
- `mode`  in  2*NREQ  encoding for requester i in bits [2i +: 2]: 00 binary, 01 Gray, 10 one-hot, 11 treated as binary.
- `gnt`  out  NREQ  one-hot grant; all zero when no owner.
- `busy`  out  1  high in RUN and DONE.
- `out`  out  W  encoded count value.
- `out_valid`  out  1  high exactly on RUN cycles.
- `done`  out  1  one-cycle pulse when a run completes.
- `abort`  out  1  one-cycle pulse when the owner drops `req` early.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any `req` is high, select the winner round-robin, searching upward from `ptr+1` modulo NREQ.
  - Latch the winner index, its `len` and its `mode`; clear `count` to 0; go to RUN.
  - If no `req` is high, stay in IDLE.
- RUN:
  - `gnt[win]=1`, `out_valid=1`, and `count` increments by 1 each cycle, modulo 2^W.
  - When `count == len_l-1` (for `len_l=0`, when `count == 2^W-1`): go to DONE and set `ptr <= win`.
  - Else, if `req[win]==0`: go to IDLE, pulse `abort`, and set `ptr <= win`.
  - Completion takes precedence over abort in the same cycle.
- DONE: `gnt[win]` stays high, `done=1`, `out_valid=0`; go to IDLE unconditionally.
- Encoding, computed combinationally from the registered `count` and latched mode:
  - Binary: `out = count`.
  - Gray: `out = count ^ (count>>1)`.
  - One-hot: `out = 1 << (count mod W)`, so it wraps every W counts.
- `out` is 0 whenever `out_valid=0`.
- Inputs `len` and `mode` are sampled only at grant; later changes have no effect on the current run.
- Non-winning `req` lines are ignored until the scheduler returns to IDLE. There is no queueing beyond the live `req` level.

## Timing
- Reset (asynchronous, `reset=0`):
  - State IDLE, `ptr=NREQ-1`, so requester 0 wins first.
  - `count=0`, and `gnt`, `busy`, `out`, `out_valid`, `done`, `abort` are all 0.
- Reset asserted mid-run: all outputs clear immediately with no `done` or `abort` pulse. Operation resumes on the first rising edge after `reset` is released.
- Grant latency: `req` sampled high at edge E0 in IDLE gives `gnt`, `busy` and `out_valid` high during the cycle after E0, with `out` = encode(0).
- Run length: `out_valid` is high for exactly `len` cycles (256 cycles for `len=0` at W=8).
- Completion sequence: `done` is high for the one cycle after the last valid value. `gnt` falls one cycle later, on the return to IDLE.
- Throughput: the minimum spacing between the last valid cycle of one run and the first valid cycle of the next run is 2 idle cycles (DONE plus IDLE).
- Abort: `abort` is high for one cycle, with `gnt=0` and `busy=0` in that same cycle. Arbitration runs again at the following edge.
- Outputs `gnt`, `busy`, `done`, `abort` and `out_valid` come directly from registers. `out` is one encode level after `count`.

## Test plan
- Reset and single requester:
  - Stimulus: `reset` low then high; `req[0]=1`, `len0=5`, `mode0=00`.
  - Required: `out` = 0,1,2,3,4 over 5 `out_valid` cycles, then `done` for 1 cycle, then `gnt` = 0.
- Gray and one-hot:
  - Stimulus: `len1=10`, `mode1=01`; then a separate run with `len1=10`, `mode1=10`.
  - Required Gray: 00,01,03,02,06,07,05,04,0C,0D.
  - Required one-hot (W=8): 01,02,04,08,10,20,40,80,01,02.
- Round-robin fairness:
  - Stimulus: all 4 `req` held high, every `len=2`.
  - Required grant order: 0,1,2,3,0; each run followed by one `done` pulse; 2 idle cycles between runs.
- Full wrap:
  - Stimulus: `len=0`, binary mode.
  - Required: 256 valid cycles, `out` 0..255, with `done` after the 255 value.
- Abort and precedence:
  - Stimulus: drop `req[2]` on the 3rd valid cycle of an 8-long run.
  - Required: `abort` pulses, no `done`, `ptr` advances so requester 3 wins next.
  - Stimulus: drop `req` on the final count cycle instead.
  - Required: `done` pulses and no `abort`.
- Reset mid-run:
  - Stimulus: assert `reset` low during count 3 of a 6-long run.
  - Required: all outputs 0 immediately; after release, requester 0 is granted first again.

Source files
------------

// File: rtl/count_run_sched.sv
// Round-robin scheduler sharing one W-bit run counter among NREQ requesters.
// The granted requester gets `len` consecutive counts in binary, Gray or one-hot form.
module count_run_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  input  logic [2*NREQ-1:0] mode,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [W-1:0]      out,
  output logic              out_valid,
  output logic              done,
  output logic              abort
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   win_nxt;
  logic            any_req;
  logic [W-1:0]    len_l;
  logic [1:0]      mode_l;
  logic [W-1:0]    count;
  logic [W-1:0]    len_a  [NREQ];
  logic [1:0]      mode_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign len_a[g]  = len[g*W +: W];
    assign mode_a[g] = mode[2*g +: 2];
  end

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % NREQ);
  endfunction

  // Search upward from ptr+1 so the previous owner is considered last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    any_req = 1'b0;
    win_nxt = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any_req && req[rr_idx(ptr, k)]) begin
        any_req = 1'b1;
        win_nxt = rr_idx(ptr, k);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ptr       <= IW'(NREQ - 1);
      win       <= '0;
      len_l     <= '0;
      mode_l    <= '0;
      count     <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            win       <= win_nxt;
            len_l     <= len_a[win_nxt];
            mode_l    <= mode_a[win_nxt];
            count     <= '0;
            gnt       <= NREQ'(1) << win_nxt;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          // len_l of 0 wraps to all-ones, giving a full 2^W run.
          if (count == len_l - W'(1)) begin
            state     <= S_DONE;
            ptr       <= win;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end else if (!req[win]) begin
            state     <= S_IDLE;
            ptr       <= win;
            gnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            abort     <= 1'b1;
          end else begin
            count <= count + W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    out = '0;
    if (out_valid) begin
      case (mode_l)
        2'b01:   out = count ^ (count >> 1);
        2'b10:   out = W'(1) << count[SW-1:0];
        default: out = count;
      endcase
    end
  end

endmodule
